// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared constants, stage indices and saturating increment for pipeline_regs
package pipeline_pkg;

  localparam int DEF_DATA_W      = 32;
  localparam int DEF_STAGES      = 4;
  localparam int DEF_STALL_STAGE = 1;
  localparam int DEF_FLUSH_DEPTH = 3;
  localparam int DEF_COUNT_W     = 16;

  localparam int IF_ID  = 0;
  localparam int ID_EX  = 1;
  localparam int EX_MEM = 2;
  localparam int MEM_WB = 3;

  typedef enum logic [1:0] {
    SM_KEEP  = 2'd0,
    SM_LOAD  = 2'd1,
    SM_HOLD  = 2'd2,
    SM_CLEAR = 2'd3
  } stage_mode_e;

  // Counters up to 32 bits wide share this; callers truncate back to their width.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
    return (v >= max_v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/pipe_stage.sv
// rtl/pipe_stage.sv - one valid+data stage register with clear > hold > load priority
module pipe_stage
  import pipeline_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              clear,
  input  logic              hold,
  input  logic              load,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (clear) begin
      valid_d = 1'b0;
      data_d  = '0;
    end else if (hold) begin
      valid_d = valid_q;
      data_d  = data_q;
    end else if (load) begin
      // invalid entries never carry stale payload
      valid_d = in_valid;
      data_d  = in_valid ? in_data : '0;
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/pipeline_regs.sv
// rtl/pipeline_regs.sv - valid-tagged stage register chain with stall bubbles, flush and event counters
module pipeline_regs
  import pipeline_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int STAGES      = DEF_STAGES,
  parameter int STALL_STAGE = DEF_STALL_STAGE,
  parameter int FLUSH_DEPTH = DEF_FLUSH_DEPTH,
  parameter int COUNT_W     = DEF_COUNT_W
) (
  input  logic                     clk,
  input  logic                     arst,
  input  logic                     enable,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     stall,
  input  logic                     flush,
  output logic                     in_accept,
  output logic [STAGES-1:0]        stage_valid,
  output logic [STAGES*DATA_W-1:0] stage_data,
  output logic [COUNT_W-1:0]       bubble_cnt,
  output logic [COUNT_W-1:0]       flush_cnt,
  output logic [COUNT_W-1:0]       retire_cnt
);

  localparam logic [31:0] CNT_MAX = (COUNT_W >= 32) ? 32'hFFFF_FFFF
                                                    : ((32'd1 << COUNT_W) - 32'd1);

  stage_mode_e       mode [STAGES];
  logic [STAGES-1:0] clear_v, hold_v, load_v;
  logic [STAGES-1:0] src_valid;
  logic [DATA_W-1:0] src_data [STAGES];
  logic [STAGES-1:0] valid_w;
  logic [DATA_W-1:0] data_w [STAGES];

  logic [COUNT_W-1:0] bubble_q, bubble_d;
  logic [COUNT_W-1:0] flush_q, flush_d;
  logic [COUNT_W-1:0] retire_q, retire_d;

  assign in_accept = enable & (~stall | flush);

  // flush outranks stall; with enable low every stage keeps its contents
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      mode[k] = SM_KEEP;
      if (enable) begin
        if (flush) begin
          mode[k] = (k < FLUSH_DEPTH) ? SM_CLEAR : SM_LOAD;
        end else if (stall) begin
          if (k <= STALL_STAGE)          mode[k] = SM_HOLD;
          else if (k == STALL_STAGE + 1) mode[k] = SM_CLEAR;
          else                           mode[k] = SM_LOAD;
        end else begin
          mode[k] = SM_LOAD;
        end
      end
    end
  end

  genvar g;
  generate
    for (g = 0; g < STAGES; g++) begin : g_stage
      if (g == 0) begin : g_src_in
        assign src_valid[g] = in_valid;
        assign src_data[g]  = in_data;
      end else begin : g_src_prev
        assign src_valid[g] = valid_w[g-1];
        assign src_data[g]  = data_w[g-1];
      end

      assign clear_v[g] = (mode[g] == SM_CLEAR);
      assign hold_v[g]  = (mode[g] == SM_HOLD);
      assign load_v[g]  = (mode[g] == SM_LOAD);

      pipe_stage #(.DATA_W(DATA_W)) u_stage (
        .clk      (clk),
        .arst     (arst),
        .clear    (clear_v[g]),
        .hold     (hold_v[g]),
        .load     (load_v[g]),
        .in_valid (src_valid[g]),
        .in_data  (src_data[g]),
        .out_valid(valid_w[g]),
        .out_data (data_w[g])
      );

      assign stage_data[g*DATA_W +: DATA_W] = data_w[g];
    end
  endgenerate

  assign stage_valid = valid_w;

  always_comb begin
    bubble_d = bubble_q;
    flush_d  = flush_q;
    retire_d = retire_q;
    if (enable) begin
      if (flush)      flush_d  = COUNT_W'(sat_inc(32'(flush_q), CNT_MAX));
      else if (stall) bubble_d = COUNT_W'(sat_inc(32'(bubble_q), CNT_MAX));
      // the last stage is always shifted out or replaced, whatever the mode
      if (valid_w[STAGES-1]) retire_d = COUNT_W'(sat_inc(32'(retire_q), CNT_MAX));
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      bubble_q <= '0;
      flush_q  <= '0;
      retire_q <= '0;
    end else begin
      bubble_q <= bubble_d;
      flush_q  <= flush_d;
      retire_q <= retire_d;
    end
  end

  assign bubble_cnt = bubble_q;
  assign flush_cnt  = flush_q;
  assign retire_cnt = retire_q;

endmodule

// File: tb/tb_pipeline_regs.sv
// tb/tb_pipeline_regs.sv - scoreboard bench for pipeline_regs (default and COUNT_W=2 instances)
module tb_pipeline_regs;

  logic        clk = 1'b0;
  logic        arst, enable, in_valid, stall, flush;
  logic [31:0] in_data;

  logic         in_accept, s_in_accept;
  logic [3:0]   stage_valid, s_stage_valid;
  logic [127:0] stage_data, s_stage_data;
  logic [15:0]  bubble_cnt, flush_cnt, retire_cnt;
  logic [1:0]   s_bubble, s_flush, s_retire;

  always #5 clk = ~clk;

  pipeline_regs dut (
    .clk(clk), .arst(arst), .enable(enable), .in_valid(in_valid), .in_data(in_data),
    .stall(stall), .flush(flush), .in_accept(in_accept), .stage_valid(stage_valid),
    .stage_data(stage_data), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt),
    .retire_cnt(retire_cnt)
  );

  pipeline_regs #(.COUNT_W(2)) dut_sat (
    .clk(clk), .arst(arst), .enable(enable), .in_valid(in_valid), .in_data(in_data),
    .stall(stall), .flush(flush), .in_accept(s_in_accept), .stage_valid(s_stage_valid),
    .stage_data(s_stage_data), .bubble_cnt(s_bubble), .flush_cnt(s_flush),
    .retire_cnt(s_retire)
  );

  typedef struct {
    logic         acc;
    logic [3:0]   v;
    logic [127:0] d;
    logic [15:0]  b, f, r;
    logic [1:0]   sb, sf, sr;
  } snap_t;

  snap_t exp_q[$];
  snap_t e;

  int n_cmp = 0;
  int n_bad = 0;

  logic        last_acc;
  logic [3:0]  m_v;
  logic [31:0] m_d [4];
  logic [15:0] m_b, m_f, m_r;
  logic [1:0]  ms_b, ms_f, ms_r;

  task automatic model_reset();
    m_v = 4'b0;
    for (int k = 0; k < 4; k++) m_d[k] = 32'h0;
    m_b = 16'h0; m_f = 16'h0; m_r = 16'h0;
    ms_b = 2'd0; ms_f = 2'd0; ms_r = 2'd0;
  endtask

  // Drive one cycle, push the spec-model expectation, and return just after the edge.
  task automatic drive_cycle(input logic en, input logic vin, input logic [31:0] din,
                             input logic st, input logic fl);
    logic [3:0]  nv;
    logic [31:0] nd [4];
    logic        sv;
    logic [31:0] sd;
    snap_t       s;
    @(negedge clk);
    enable = en; in_valid = vin; in_data = din; stall = st; flush = fl;
    #1;
    last_acc = in_accept;
    s.acc = en & (~st | fl);
    if (en) begin
      for (int k = 0; k < 4; k++) begin
        sv = (k == 0) ? vin : m_v[k-1];
        sd = (k == 0) ? (vin ? din : 32'h0) : m_d[k-1];
        if (fl) begin
          nv[k] = (k < 3) ? 1'b0 : sv;
          nd[k] = (k < 3) ? 32'h0 : sd;
        end else if (st) begin
          if (k <= 1)      begin nv[k] = m_v[k]; nd[k] = m_d[k]; end
          else if (k == 2) begin nv[k] = 1'b0;   nd[k] = 32'h0;  end
          else             begin nv[k] = sv;     nd[k] = sd;     end
        end else begin
          nv[k] = sv; nd[k] = sd;
        end
      end
      if (m_v[3]) begin
        if (m_r != 16'hFFFF) m_r = m_r + 16'd1;
        if (ms_r != 2'd3) ms_r = ms_r + 2'd1;
      end
      if (fl) begin
        if (m_f != 16'hFFFF) m_f = m_f + 16'd1;
        if (ms_f != 2'd3) ms_f = ms_f + 2'd1;
      end else if (st) begin
        if (m_b != 16'hFFFF) m_b = m_b + 16'd1;
        if (ms_b != 2'd3) ms_b = ms_b + 2'd1;
      end
      m_v = nv;
      for (int k = 0; k < 4; k++) m_d[k] = nd[k];
    end
    s.v = m_v; s.d = {m_d[3], m_d[2], m_d[1], m_d[0]};
    s.b = m_b; s.f = m_f; s.r = m_r; s.sb = ms_b; s.sf = ms_f; s.sr = ms_r;
    exp_q.push_back(s);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    arst = 1'b1; enable = 1'b1; in_valid = 1'b0; in_data = 32'h0; stall = 1'b0; flush = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({stage_valid, stage_data, bubble_cnt, flush_cnt, retire_cnt} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs got v=%b d=%h b=%0d f=%0d r=%0d want all zero",
               stage_valid, stage_data, bubble_cnt, flush_cnt, retire_cnt);
    end
    n_cmp++;
    if ({s_stage_valid, s_stage_data, s_bubble, s_flush, s_retire} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs_sat got v=%b b=%0d f=%0d r=%0d want all zero",
               s_stage_valid, s_bubble, s_flush, s_retire);
    end
    @(negedge clk);
    arst = 1'b0;
  endtask

  task automatic test_streaming();
    for (int i = 0; i < 5; i++) begin
      drive_cycle(1'b1, 1'b1, 32'h10 + i, 1'b0, 1'b0);
      e = exp_q.pop_front();
      n_cmp++;
      if ({stage_valid, stage_data} !== {e.v, e.d}) begin
        n_bad++;
        $display("FAIL stream_stages[%0d] got %b/%h want %b/%h", i, stage_valid, stage_data, e.v, e.d);
      end
      n_cmp++;
      if ({bubble_cnt, flush_cnt, retire_cnt, s_bubble, s_flush, s_retire} !==
          {e.b, e.f, e.r, e.sb, e.sf, e.sr}) begin
        n_bad++;
        $display("FAIL stream_counters[%0d] got r=%0d want r=%0d", i, retire_cnt, e.r);
      end
      if (i == 3) begin
        n_cmp++;
        if (stage_data[127:96] !== 32'h10 || stage_valid !== 4'b1111) begin
          n_bad++;
          $display("FAIL stream_latency got v=%b s3=%h want 1111/00000010", stage_valid, stage_data[127:96]);
        end
      end
      if (i == 4) begin
        n_cmp++;
        if (retire_cnt !== 16'd1) begin
          n_bad++;
          $display("FAIL stream_retire got %0d want 1", retire_cnt);
        end
      end
    end
  endtask

  task automatic test_stall();
    drive_cycle(1'b1, 1'b1, 32'hA0, 1'b0, 1'b0);
    void'(exp_q.pop_front());
    drive_cycle(1'b1, 1'b1, 32'hA1, 1'b0, 1'b0);
    void'(exp_q.pop_front());
    for (int i = 0; i < 2; i++) begin
      drive_cycle(1'b1, 1'b1, 32'hA2, 1'b1, 1'b0);
      e = exp_q.pop_front();
      n_cmp++;
      if (last_acc !== 1'b0) begin
        n_bad++;
        $display("FAIL stall_accept[%0d] got %b want 0", i, last_acc);
      end
      n_cmp++;
      if (stage_data[31:0] !== 32'hA1 || stage_data[63:32] !== 32'hA0 ||
          stage_valid[2] !== 1'b0 || stage_data[95:64] !== 32'h0) begin
        n_bad++;
        $display("FAIL stall_hold[%0d] got v=%b d=%h want s0=a1 s1=a0 s2 bubble", i, stage_valid, stage_data);
      end
      n_cmp++;
      if ({stage_valid, stage_data, bubble_cnt, s_bubble} !== {e.v, e.d, e.b, e.sb}) begin
        n_bad++;
        $display("FAIL stall_model[%0d] got %b/%h b=%0d want %b/%h b=%0d",
                 i, stage_valid, stage_data, bubble_cnt, e.v, e.d, e.b);
      end
    end
    n_cmp++;
    if (bubble_cnt !== 16'd2) begin
      n_bad++;
      $display("FAIL stall_bubble_cnt got %0d want 2", bubble_cnt);
    end
  endtask

  task automatic test_flush(input logic with_stall, input logic [15:0] want_f);
    logic [15:0] b_before;
    for (int i = 0; i < 4; i++) begin
      drive_cycle(1'b1, 1'b1, 32'hB0 + i, 1'b0, 1'b0);
      void'(exp_q.pop_front());
    end
    b_before = m_b;
    drive_cycle(1'b1, 1'b1, 32'hBF, with_stall, 1'b1);
    e = exp_q.pop_front();
    n_cmp++;
    if (last_acc !== 1'b1) begin
      n_bad++;
      $display("FAIL flush_accept(stall=%b) got %b want 1", with_stall, last_acc);
    end
    n_cmp++;
    if (stage_valid !== 4'b1000 || stage_data !== {32'hB1, 96'h0}) begin
      n_bad++;
      $display("FAIL flush_stages(stall=%b) got %b/%h want 1000/b1 on stage 3", with_stall, stage_valid, stage_data);
    end
    n_cmp++;
    if (flush_cnt !== want_f || bubble_cnt !== b_before) begin
      n_bad++;
      $display("FAIL flush_counters(stall=%b) got f=%0d b=%0d want f=%0d b=%0d",
               with_stall, flush_cnt, bubble_cnt, want_f, b_before);
    end
    n_cmp++;
    if ({bubble_cnt, flush_cnt, retire_cnt, s_bubble, s_flush, s_retire} !==
        {e.b, e.f, e.r, e.sb, e.sf, e.sr}) begin
      n_bad++;
      $display("FAIL flush_model(stall=%b) got r=%0d sf=%0d want r=%0d sf=%0d",
               with_stall, retire_cnt, s_flush, e.r, e.sf);
    end
  endtask

  task automatic test_disable();
    drive_cycle(1'b1, 1'b1, 32'hC0, 1'b0, 1'b0);
    void'(exp_q.pop_front());
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b0, 1'b1, 32'hC1 + i, 1'b1, 1'b1);
      e = exp_q.pop_front();
      n_cmp++;
      if (last_acc !== 1'b0) begin
        n_bad++;
        $display("FAIL disable_accept[%0d] got %b want 0", i, last_acc);
      end
      n_cmp++;
      if ({stage_valid, stage_data, bubble_cnt, flush_cnt, retire_cnt} !==
          {e.v, e.d, e.b, e.f, e.r}) begin
        n_bad++;
        $display("FAIL disable_hold[%0d] got %b/%h b=%0d f=%0d r=%0d want %b/%h b=%0d f=%0d r=%0d",
                 i, stage_valid, stage_data, bubble_cnt, flush_cnt, retire_cnt,
                 e.v, e.d, e.b, e.f, e.r);
      end
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 5; i++) begin
      drive_cycle(1'b1, 1'b1, 32'hD0 + i, 1'b1, 1'b0);
      e = exp_q.pop_front();
      n_cmp++;
      if ({s_bubble, s_flush, s_retire, bubble_cnt} !== {e.sb, e.sf, e.sr, e.b}) begin
        n_bad++;
        $display("FAIL sat_model[%0d] got sb=%0d sf=%0d sr=%0d b=%0d want sb=%0d sf=%0d sr=%0d b=%0d",
                 i, s_bubble, s_flush, s_retire, bubble_cnt, e.sb, e.sf, e.sr, e.b);
      end
    end
    n_cmp++;
    if (s_bubble !== 2'd3) begin
      n_bad++;
      $display("FAIL sat_bubble got %0d want 3", s_bubble);
    end
    @(negedge clk);
    arst = 1'b1;
    #1;
    n_cmp++;
    if ({stage_valid, stage_data, bubble_cnt, flush_cnt, retire_cnt,
         s_stage_valid, s_stage_data, s_bubble, s_flush, s_retire} !== '0) begin
      n_bad++;
      $display("FAIL async_reset got v=%b b=%0d f=%0d r=%0d sv=%b sb=%0d want all zero",
               stage_valid, bubble_cnt, flush_cnt, retire_cnt, s_stage_valid, s_bubble);
    end
    #1;
    arst = 1'b0;
    model_reset();
    drive_cycle(1'b1, 1'b1, 32'h55, 1'b0, 1'b0);
    e = exp_q.pop_front();
    n_cmp++;
    if ({stage_valid, stage_data, retire_cnt} !== {e.v, e.d, e.r} || stage_data[31:0] !== 32'h55) begin
      n_bad++;
      $display("FAIL reset_resume got %b/%h want %b/%h", stage_valid, stage_data, e.v, e.d);
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_stall();
    test_flush(1'b0, 16'd1);
    test_flush(1'b1, 16'd2);
    test_disable();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
